// File: rtl/seg7_frame_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the displayed
// hex word, publishing each complete NDIG-digit frame with a one-cycle pulse.
module seg7_frame_decoder #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NDIG-1:0]     anode,
  input  logic [7:0]          catode,
  output logic [4*NDIG-1:0]   value,
  output logic [NDIG-1:0]     dp,
  output logic [NDIG-1:0]     err_digits,
  output logic                frame_valid
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {SYNC, COLLECT} state_t;

  state_t state_q, state_d;

  logic [NDIG-1:0]   s_an_q, s_an_d, p_an_q, p_an_d;
  logic [7:0]        s_cat_q, s_cat_d, p_cat_q, p_cat_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] sh_val_q, sh_val_d, value_q, value_d;
  logic [NDIG-1:0]   sh_dp_q, sh_dp_d, dp_q, dp_d;
  logic [NDIG-1:0]   sh_err_q, sh_err_d, err_q, err_d;
  logic              fv_q, fv_d;

  logic [NDIG-1:0]   strobe_inv;
  logic              strobe_ok, same, accept, capture, complete;
  logic [IW-1:0]     digit;
  logic [7:0]        seg;
  logic [4:0]        glyph;

  // Returns {no_match, nibble}; the argument is the lit-segment A..G field.
  function automatic logic [4:0] decode_glyph(input logic [6:0] abcdefg);
    case ({abcdefg, 1'b0})
      8'hFC: decode_glyph = 5'h00;
      8'h60: decode_glyph = 5'h01;
      8'hDA: decode_glyph = 5'h02;
      8'hF2: decode_glyph = 5'h03;
      8'h66: decode_glyph = 5'h04;
      8'hB6: decode_glyph = 5'h05;
      8'hBE: decode_glyph = 5'h06;
      8'hE0: decode_glyph = 5'h07;
      8'hFE: decode_glyph = 5'h08;
      8'hF6: decode_glyph = 5'h09;
      8'hEE: decode_glyph = 5'h0A;
      8'h3E: decode_glyph = 5'h0B;
      8'h9C: decode_glyph = 5'h0C;
      8'h7A: decode_glyph = 5'h0D;
      8'h9E: decode_glyph = 5'h0E;
      8'h8E: decode_glyph = 5'h0F;
      default: decode_glyph = 5'h10;
    endcase
  endfunction

  // Input stage and one-cycle history of the registered pair.
  always_comb begin
    s_an_d  = anode;
    s_cat_d = catode;
    p_an_d  = s_an_q;
    p_cat_d = s_cat_q;
  end

  // A valid strobe has exactly one anode low.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    digit      = '0;
    strobe_inv = ~s_an_q;
    strobe_ok  = (strobe_inv != '0) && ((strobe_inv & (strobe_inv - NDIG'(1))) == '0);
    for (int i = 0; i < NDIG; i++) begin
      if (!s_an_q[i]) digit = IW'(i);
    end
  end

  // Saturating stability counter; accept fires only on the cycle it reaches the limit.
  always_comb begin
    same  = (s_an_q == p_an_q) && (s_cat_q == p_cat_q);
    cnt_d = '0;
    if (strobe_ok && same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    accept = strobe_ok && (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
  end

  always_comb begin
    seg   = ~s_cat_q;
    glyph = decode_glyph(seg[7:1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (accept && (digit == '0)) state_d = COLLECT;
      COLLECT: state_d = COLLECT;
      default: state_d = SYNC;
    endcase
  end

  // In SYNC only a digit-0 accept is kept, so frames always start aligned.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      SYNC:    capture = accept && (digit == '0);
      COLLECT: capture = accept;
      default: capture = 1'b0;
    endcase
  end

  // Shadow capture and frame publish; an accept in the publish cycle joins the new frame.
  always_comb begin
    complete = &mask_q;
    mask_d   = complete ? '0 : mask_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_err_d = sh_err_q;
    if (capture) begin
      mask_d[digit]                = 1'b1;
      sh_val_d[int'(digit)*4 +: 4] = glyph[3:0];
      sh_dp_d[digit]               = seg[0];
      sh_err_d[digit]              = glyph[4];
    end
    fv_d    = complete;
    value_d = complete ? sh_val_q : value_q;
    dp_d    = complete ? sh_dp_q  : dp_q;
    err_d   = complete ? sh_err_q : err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_an_q   <= '0;
      s_cat_q  <= '0;
      p_an_q   <= '0;
      p_cat_q  <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      // NOTE: the shadow is a handful of flops, not a RAM, so it takes the reset too.
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_err_q <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      s_an_q   <= s_an_d;
      s_cat_q  <= s_cat_d;
      p_an_q   <= p_an_d;
      p_cat_q  <= p_cat_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      sh_err_q <= sh_err_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign err_digits  = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed scans plus random strobes, checked
// every cycle against a run-length / frame-assembly reference model.
module tb_seg7_frame_decoder;

  localparam int NDIG = 4;
  localparam int S    = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  err_digits;
  logic        frame_valid;

  int checks   = 0;
  int failures = 0;
  int fv_seen  = 0;

  seg7_frame_decoder #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .anode       (anode),
    .catode      (catode),
    .value       (value),
    .dp          (dp),
    .err_digits  (err_digits),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] glyph_tab [16];
  initial begin
    glyph_tab[0]  = 8'hFC; glyph_tab[1]  = 8'h60; glyph_tab[2]  = 8'hDA; glyph_tab[3]  = 8'hF2;
    glyph_tab[4]  = 8'h66; glyph_tab[5]  = 8'hB6; glyph_tab[6]  = 8'hBE; glyph_tab[7]  = 8'hE0;
    glyph_tab[8]  = 8'hFE; glyph_tab[9]  = 8'hF6; glyph_tab[10] = 8'hEE; glyph_tab[11] = 8'h3E;
    glyph_tab[12] = 8'h9C; glyph_tab[13] = 8'h7A; glyph_tab[14] = 8'h9E; glyph_tab[15] = 8'h8E;
  end

  typedef struct packed {
    logic        fv;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  // Reference model state: pin run length, frame assembly, two-cycle output delay.
  logic [3:0]  prev_an;
  logic [7:0]  prev_cat;
  bit          have_prev;
  int          run;
  bit          m_sync;
  logic [3:0]  m_mask, m_dp, m_err;
  logic [15:0] m_val;
  frame_t      st0, st1, cur;
  logic [15:0] out_val;
  logic [3:0]  out_dp, out_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    have_prev = 0; run = 0; m_sync = 1; m_mask = '0;
    m_val = '0; m_dp = '0; m_err = '0;
    st0 = '0; st1 = '0; cur = '0;
    out_val = '0; out_dp = '0; out_err = '0;
  endtask

  task automatic model_accept(input int d, input logic [7:0] c);
    logic [7:0] seg;
    logic [3:0] nib;
    bit         bad;
    seg = ~c; nib = '0; bad = 1;
    for (int i = 0; i < 16; i++) begin
      if ({seg[7:1], 1'b0} == glyph_tab[i]) begin nib = 4'(i); bad = 0; end
    end
    if (!(m_sync && d != 0)) begin
      m_sync = 0;
      m_val[d*4 +: 4] = nib;
      m_dp[d]   = seg[0];
      m_err[d]  = bad;
      m_mask[d] = 1'b1;
      if (&m_mask) begin
        st0.fv = 1'b1; st0.val = m_val; st0.dp = m_dp; st0.err = m_err;
        m_mask = '0;
      end
    end
  endtask

  // One rising edge seen by the model: pins held S edges with a single low anode accept.
  task automatic model_edge();
    int d;
    if (have_prev && anode == prev_an && catode == prev_cat) run++;
    else run = 1;
    have_prev = 1; prev_an = anode; prev_cat = catode;
    cur = st1; st1 = st0; st0 = '0;
    if (run == S && $countones(~anode) == 1) begin
      d = 0;
      for (int i = 0; i < NDIG; i++) if (!anode[i]) d = i;
      model_accept(d, catode);
    end
    if (cur.fv) begin
      out_val = cur.val; out_dp = cur.dp; out_err = cur.err;
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] c, input int n);
    for (int k = 0; k < n; k++) begin
      anode = a; catode = c;
      @(posedge clk); #1;
      model_edge();
      if (frame_valid) fv_seen++;
      check("frame_valid", frame_valid, cur.fv);
      check("value", value, out_val);
      check("dp", dp, out_dp);
      check("err_digits", err_digits, out_err);
      @(negedge clk);
    end
  endtask

  task automatic show(input int d, input int nib, input bit p, input int n);
    logic [3:0] a;
    a = ~(4'(1) << d);
    step(a, ~(glyph_tab[nib] | {7'b0, p}), n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value"}, value, 0);
    check({tag, "_dp"}, dp, 0);
    check({tag, "_err"}, err_digits, 0);
    check({tag, "_fv"}, frame_valid, 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; anode = 4'hF; catode = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("por");
    reset = 1'b0;

    // Start mid-scan at digit 2, then an all-low anode, then a real scan of "1234".
    show(2, 2, 0, 8);
    show(3, 1, 0, 8);
    step(4'b0000, ~glyph_tab[8], 8);
    show(0, 4, 0, 8);
    show(1, 3, 0, 8);
    check("sync_no_early_frame", fv_seen, 0);
    show(2, 2, 0, 8);
    show(3, 1, 0, 8);
    check("scan_frames", fv_seen, 1);
    check("scan_value", value, 32'h1234);
    check("scan_err", err_digits, 0);
    check("scan_dp", dp, 0);

    // Glitch: three-cycle hold is ignored, four-cycle hold is taken.
    show(0, 4, 0, 8);
    show(1, 5, 0, 3);
    show(2, 2, 0, 8);
    show(3, 1, 0, 8);
    check("glitch_no_frame", fv_seen, 1);
    show(1, 3, 0, 4);
    step(4'hF, 8'hFF, 4);
    check("glitch_frames", fv_seen, 2);
    check("glitch_value", value, 32'h1234);

    // Unrecognised glyph on digit 2 still completes the frame.
    show(0, 4, 0, 8);
    show(1, 3, 0, 8);
    step(4'b1011, ~8'h02, 8);
    show(3, 1, 0, 8);
    check("badglyph_frames", fv_seen, 3);
    check("badglyph_value", value, 32'h1034);
    check("badglyph_err", err_digits, 32'h4);
    check("badglyph_dp", dp, 0);

    // Decimal point lit on digit 1 showing "A".
    show(0, 4, 0, 8);
    step(4'b1101, ~8'hEF, 8);
    show(2, 2, 0, 8);
    show(3, 1, 0, 8);
    check("dp_frames", fv_seen, 4);
    check("dp_value", value, 32'h12A4);
    check("dp_dp", dp, 32'h2);
    check("dp_err", err_digits, 0);

    // Reset mid-frame: partial data is dropped and digit 0 must be seen again.
    show(0, 5, 0, 8);
    show(1, 6, 0, 5);
    do_reset();
    show(1, 8, 0, 8);
    show(2, 9, 0, 8);
    show(3, 0, 0, 8);
    check("post_reset_no_frame", fv_seen, 4);
    show(0, 7, 0, 8);
    show(1, 8, 0, 8);
    show(2, 9, 0, 8);
    show(3, 0, 0, 8);
    check("post_reset_frames", fv_seen, 5);
    check("post_reset_value", value, 32'h0987);

    // Random strobes, glyphs and hold lengths against the model.
    for (int k = 0; k < 300; k++) begin
      logic [3:0] a;
      logic [7:0] c;
      if ($urandom_range(0, 99) < 85) begin
        a = ~(4'(1) << $urandom_range(0, 3));
      end else begin
        a = 4'($urandom);
        if ($countones(~a) == 1) a = 4'hF;
      end
      if ($urandom_range(0, 9) < 7) c = ~(glyph_tab[$urandom_range(0, 15)] | 8'($urandom_range(0, 1)));
      else c = 8'($urandom);
      step(a, c, $urandom_range(1, 8));
      if (k == 150) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
